wptr_handler_lvl: RTL and testbench

Write-side pointer handler for the asynchronous FIFO, in the write clock domain. It is the counterpart of the read pointer handler.
- Advances the binary and Gray write pointers on accepted writes.
- Generates registered full, almost_full and fill-level outputs from the read Gray pointer after it has been synchronised into this domain.
- Holds a sticky overflow flag for writes attempted while full.
- Feeds the FIFO memory write port and the write-to-read pointer synchroniser.

---
 rtl/wptr_handler_lvl_pkg.sv | 27 ++
 rtl/wptr_handler_lvl_if.sv | 25 ++
 rtl/wptr_handler_lvl_gray2bin_conv.sv | 14 +
 rtl/wptr_handler_lvl.sv | 75 +++++++
 tb/tb_wptr_handler_lvl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/wptr_handler_lvl_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth derivation.
// Reused unchanged by the read pointer handler.
package afifo_pkg;

    localparam int unsigned PTR_W_MAX = 10;
    localparam int unsigned VEC_W     = PTR_W_MAX + 1;

    typedef logic [VEC_W-1:0] ptr_vec_t;

    function automatic int unsigned depth(input int unsigned ptr_w);
        return 1 << ptr_w;
    endfunction

    // Narrower pointers are passed zero-extended; leading zeros leave both conversions exact.
    function automatic ptr_vec_t bin2gray(input ptr_vec_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic ptr_vec_t gray2bin(input ptr_vec_t gray);
        ptr_vec_t bin;
        for (int unsigned i = 0; i < VEC_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_handler_lvl_if.sv
// Write-side pointer bus between the producer/sync logic and the write pointer handler.
interface wptr_handler_lvl_if #(
    parameter int unsigned Ptr_Width = 3
);
    logic                 w_en;
    logic                 clr_ovf;
    logic [Ptr_Width:0]   g_rptr_sync;
    logic [Ptr_Width:0]   b_wptr;
    logic [Ptr_Width:0]   g_wptr;
    logic                 w_ack;
    logic                 full;
    logic                 almost_full;
    logic [Ptr_Width:0]   wlevel;
    logic                 overflow;

    modport master (
        output w_en, clr_ovf, g_rptr_sync,
        input  b_wptr, g_wptr, w_ack, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  w_en, clr_ovf, g_rptr_sync,
        output b_wptr, g_wptr, w_ack, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/wptr_handler_lvl_gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule

// File: rtl/wptr_handler_lvl.sv
// Write-domain pointer handler: binary/Gray write pointers, full/almost-full/level flags
// derived from the synchronised read Gray pointer, and a sticky overflow flag.
module wptr_handler_lvl
    import afifo_pkg::*;
#(
    parameter int unsigned Ptr_Width      = 3,
    parameter int unsigned Almost_Full_Th = 6
) (
    input logic            wclk,
    input logic            wrst,
    wptr_handler_lvl_if.slave bus
);
    localparam int unsigned P     = Ptr_Width;
    localparam int unsigned DEPTH = depth(P);
    localparam logic [P:0]  AF_TH = (P+1)'(Almost_Full_Th);

    logic [P:0] b_wptr_q, g_wptr_q, wlevel_q, g_rptr_prev;
    logic [P:0] b_next, g_next, rbin, lvl_next;
    logic       full_q, af_q, ovf_q, w_ack, wfull;

    gray2bin_conv #(.W(P + 1)) u_rbin (
        .gray (bus.g_rptr_sync),
        .bin  (rbin)
    );

    always_comb begin
        w_ack    = bus.w_en && !full_q;
        b_next   = b_wptr_q + {{P{1'b0}}, w_ack};
        g_next   = (b_next >> 1) ^ b_next;
        // Full when the next write pointer is exactly one lap ahead of the read pointer.
        wfull    = (g_next == {~bus.g_rptr_sync[P:P-1], bus.g_rptr_sync[P-2:0]});
        lvl_next = b_next - rbin;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            b_wptr_q    <= '0;
            g_wptr_q    <= '0;
            wlevel_q    <= '0;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            ovf_q       <= 1'b0;
            g_rptr_prev <= '0;
        end else begin
            b_wptr_q    <= b_next;
            g_wptr_q    <= g_next;
            wlevel_q    <= lvl_next;
            full_q      <= wfull;
            af_q        <= (lvl_next >= AF_TH);
            g_rptr_prev <= bus.g_rptr_sync;
            if (bus.w_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.b_wptr      = b_wptr_q;
    assign bus.g_wptr      = g_wptr_q;
    assign bus.w_ack       = w_ack;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wlevel      = wlevel_q;
    assign bus.overflow    = ovf_q;

    // The synchronised read pointer may move at most one Gray step per write clock.
    a_rptr_one_step: assert property (@(posedge wclk) disable iff (wrst)
        $countones(bus.g_rptr_sync ^ g_rptr_prev) <= 1)
        else $error("g_rptr_sync moved more than one Gray step");

    a_depth_legal: assert property (@(posedge wclk) disable iff (wrst)
        DEPTH >= 4 && Almost_Full_Th >= 1 && Almost_Full_Th <= DEPTH);

endmodule

// File: tb/tb_wptr_handler_lvl.sv
// Self-checking bench for wptr_handler_lvl: directed vector table, corner sequences, random traffic.
module tb_wptr_handler_lvl;
    localparam int PW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    always #5 wclk = ~wclk;

    wptr_handler_lvl_if #(.Ptr_Width(PW)) bus ();

    wptr_handler_lvl #(.Ptr_Width(PW), .Almost_Full_Th(AF)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model in terms of write/read counts.
    int wr_m, rd_m, lvl_m;
    bit full_m, af_m, ovf_m;

    typedef struct {
        bit         we;
        bit         clr;
        bit         rd;
        logic [3:0] b;
        logic [3:0] g;
        bit         full;
        bit         af;
        int         lvl;
        bit         ovf;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [3:0] gray4(input int n);
        logic [3:0] v;
        v = 4'(n % 16);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr_m = 0; rd_m = 0; lvl_m = 0;
        full_m = 0; af_m = 0; ovf_m = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".b_wptr"}, int'(bus.b_wptr), wr_m % 16);
        check({tag, ".g_wptr"}, int'(bus.g_wptr), int'(gray4(wr_m)));
        check({tag, ".full"}, int'(bus.full), int'(full_m));
        check({tag, ".almost_full"}, int'(bus.almost_full), int'(af_m));
        check({tag, ".wlevel"}, int'(bus.wlevel), lvl_m);
        check({tag, ".overflow"}, int'(bus.overflow), int'(ovf_m));
    endtask

    // Entered and left at posedge+1: drive inputs, check w_ack, clock, check registered outputs.
    task automatic step(input bit we, input bit clr, input bit rd_adv);
        bit ack;
        if (rd_adv && rd_m < wr_m) rd_m++;
        bus.w_en        = we;
        bus.clr_ovf     = clr;
        bus.g_rptr_sync = gray4(rd_m);
        #1;
        ack = we && !full_m;
        check("w_ack", int'(bus.w_ack), int'(ack));
        if (we && full_m)  ovf_m = 1;
        else if (clr)      ovf_m = 0;
        wr_m  += int'(ack);
        lvl_m  = wr_m - rd_m;
        full_m = (lvl_m == DEPTH);
        af_m   = (lvl_m >= AF);
        @(posedge wclk);
        #1;
        check_all("step");
    endtask

    // Short reset pulse between clock edges; read side is reset alongside.
    task automatic do_reset();
        #2;
        wrst            = 1'b1;
        bus.w_en        = 1'b0;
        bus.clr_ovf     = 1'b0;
        bus.g_rptr_sync = '0;
        #1;
        check("async_rst.b_wptr", int'(bus.b_wptr), 0);
        check("async_rst.g_wptr", int'(bus.g_wptr), 0);
        check("async_rst.full", int'(bus.full), 0);
        check("async_rst.almost_full", int'(bus.almost_full), 0);
        check("async_rst.wlevel", int'(bus.wlevel), 0);
        check("async_rst.overflow", int'(bus.overflow), 0);
        #2;
        wrst = 1'b0;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bus.w_en        = 1'b0;
        bus.clr_ovf     = 1'b0;
        bus.g_rptr_sync = '0;
        model_reset();

        // Fill, overflow handling and release from full.
        //               we clr rd  b      g      full af lvl ovf
        vecs.push_back('{1, 0, 0, 4'h1, 4'b0001, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 0, 4'h2, 4'b0011, 0, 0, 2, 0});
        vecs.push_back('{1, 0, 0, 4'h3, 4'b0010, 0, 0, 3, 0});
        vecs.push_back('{1, 0, 0, 4'h4, 4'b0110, 0, 0, 4, 0});
        vecs.push_back('{1, 0, 0, 4'h5, 4'b0111, 0, 0, 5, 0});
        vecs.push_back('{1, 0, 0, 4'h6, 4'b0101, 0, 1, 6, 0});
        vecs.push_back('{1, 0, 0, 4'h7, 4'b0100, 0, 1, 7, 0});
        vecs.push_back('{1, 0, 0, 4'h8, 4'b1100, 1, 1, 8, 0});
        vecs.push_back('{1, 0, 0, 4'h8, 4'b1100, 1, 1, 8, 1});
        vecs.push_back('{1, 0, 0, 4'h8, 4'b1100, 1, 1, 8, 1});
        vecs.push_back('{0, 1, 0, 4'h8, 4'b1100, 1, 1, 8, 0});
        vecs.push_back('{1, 1, 0, 4'h8, 4'b1100, 1, 1, 8, 1});
        vecs.push_back('{0, 1, 0, 4'h8, 4'b1100, 1, 1, 8, 0});
        vecs.push_back('{0, 0, 1, 4'h8, 4'b1100, 0, 1, 7, 0});
        vecs.push_back('{1, 0, 0, 4'h9, 4'b1101, 1, 1, 8, 0});

        // Reset state
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
        #1;
        check("reset.b_wptr", int'(bus.b_wptr), 0);
        check("reset.g_wptr", int'(bus.g_wptr), 0);
        check("reset.full", int'(bus.full), 0);
        check("reset.almost_full", int'(bus.almost_full), 0);
        check("reset.wlevel", int'(bus.wlevel), 0);
        check("reset.overflow", int'(bus.overflow), 0);
        check("reset.w_ack", int'(bus.w_ack), 0);
        @(posedge wclk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].clr, vecs[i].rd);
            check($sformatf("vec%0d.b_wptr", i), int'(bus.b_wptr), int'(vecs[i].b));
            check($sformatf("vec%0d.g_wptr", i), int'(bus.g_wptr), int'(vecs[i].g));
            check($sformatf("vec%0d.full", i), int'(bus.full), int'(vecs[i].full));
            check($sformatf("vec%0d.almost_full", i), int'(bus.almost_full), int'(vecs[i].af));
            check($sformatf("vec%0d.wlevel", i), int'(bus.wlevel), vecs[i].lvl);
            check($sformatf("vec%0d.overflow", i), int'(bus.overflow), int'(vecs[i].ovf));
        end

        // Reset mid-fill, then resume from zero
        do_reset();
        repeat (5) step(1, 0, 0);
        check("midfill.wlevel", int'(bus.wlevel), 5);
        do_reset();
        step(1, 0, 0);
        check("resume.b_wptr", int'(bus.b_wptr), 1);

        // Wrap of the extended pointer back to zero
        do_reset();
        repeat (8) step(1, 0, 0);
        repeat (8) step(0, 0, 1);
        check("drained.wlevel", int'(bus.wlevel), 0);
        check("drained.g_rptr", int'(bus.g_rptr_sync), 4'b1100);
        repeat (8) step(1, 0, 0);
        check("wrap.b_wptr", int'(bus.b_wptr), 0);
        check("wrap.g_wptr", int'(bus.g_wptr), 0);
        check("wrap.full", int'(bus.full), 1);
        check("wrap.wlevel", int'(bus.wlevel), 8);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            if (i < 150)
                step(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 2) == 1);
            else
                step(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
